point_spawner: RTL and testbench
================================

Name: point_spawner

Overview:
- Parametrised successor to the single-point generator in the snake game.
- Keeps up to N_POINTS food points live on the map, picking coordinates with a seedable Galois LFSR.
- Rejects candidates that land on occupied tiles (via a tile-read port) or on an already-placed point.
- Hands each accepted point to the map-update logic over a valid/ready handshake, and removes points when a snake eats them.

Parameters:
- MAP_W, 32: map width in tiles; column 0 and column MAP_W-1 are walls.
- MAP_H, 24: map height in tiles; row 0 and row MAP_H-1 are walls.
- N_POINTS, 4: maximum number of simultaneously live points (1..8).
- LFSR_W, 16: LFSR width (fixed taps below; must be 16).
- MAX_TRIES, 16: candidate attempts per placement before a fail pulse.

Ports:
- clk_75  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  high while the game mode is GAME.
- clear  in  1  one-cycle pulse; empties the point table (new round).
- seed_load  in  1  loads seed into the LFSR.
- seed  in  LFSR_W  seed value.
- eat_valid  in  1  a point was consumed this cycle.
- eat_x / eat_y  in  XW / YW  coordinates of the consumed point. XW = $clog2(MAP_W), YW = $clog2(MAP_H).
- tile_rd_en  out  1  tile probe strobe.
- tile_rd_x / tile_rd_y  out  XW / YW  probe coordinates.
- tile_occupied  in  1  probe result; valid exactly 1 cycle after tile_rd_en.
- place_valid  out  1  point offered to map logic.
- place_x / place_y  out  XW / YW  offered coordinates.
- place_ready  in  1  map logic accepts the offered point.
- active_count  out  $clog2(N_POINTS+1)  number of live points.
- busy  out  1  FSM not in IDLE.
- fail  out  1  one-cycle pulse: MAX_TRIES candidates were rejected.

Behaviour:
- Reset:
  - LFSR = 1; point table empty; active_count = 0; FSM = IDLE; try counter = 0.
  - tile_rd_en, place_valid, busy, fail = 0; place_x, place_y, tile_rd_x, tile_rd_y = 0.
- LFSR:
  - Galois, right shift, feedback mask 16'hB400; advances every cycle when not in reset.
  - seed_load has priority over the advance; a seed of 0 loads as 1.
- Candidate coordinates, both always inside the walls:
  - cx = (lfsr[7:0] % (MAP_W-2)) + 1, range 1..MAP_W-2.
  - cy = (lfsr[15:8] % (MAP_H-2)) + 1, range 1..MAP_H-2.
- FSM states: IDLE, PICK, PROBE, CHECK, PLACE.
  - IDLE -> PICK when enable && active_count < N_POINTS && !clear.
  - PICK: latch cx/cy into the candidate register; -> PROBE.
  - PROBE: drive tile_rd_en = 1 with the candidate on tile_rd_x/y for 1 cycle; -> CHECK.
  - CHECK: sample tile_occupied. The candidate is rejected if tile_occupied is 1 OR it equals any valid table entry.
    - Rejected, try counter < MAX_TRIES-1: counter++, -> PICK.
    - Rejected, final try: pulse fail, counter = 0, -> IDLE.
    - Accepted: -> PLACE.
  - PLACE: place_valid = 1; place_x/y hold the candidate and stay stable until accepted.
    - On place_valid && place_ready: write the candidate into the lowest free slot, active_count++, counter = 0, -> IDLE.
- Latency: with a free first candidate, place_valid rises on the 4th clk_75 edge after IDLE sees a deficit.
- Eat: on eat_valid, invalidate the table entry matching (eat_x, eat_y); active_count-- on the following edge. No match -> no effect.
- Simultaneous eat and place accept in the same cycle: both apply; active_count is net unchanged.
- enable low: FSM -> IDLE on the next edge, and any in-flight candidate is dropped. Exception: if PLACE and place_ready are high in that same cycle, the accept completes. The table is retained.
- clear: empties the table and sets active_count = 0; FSM -> IDLE; clear beats a same-cycle accept or eat.
- Reset mid-operation: immediate return to the reset state on the next edge; no place_valid leaks.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Reset: hold rst 3 cycles -> active_count = 0, place_valid = 0, tile_rd_en = 0, fail = 0, busy = 0.
- Fill: seed_load 16'hACE1, enable = 1, tile_occupied = 0, place_ready = 1 -> exactly 4 accepts, active_count steps 1..4; all coordinates distinct with x in 1..30 and y in 1..22; first place_valid 4 cycles after enable; then busy = 0 and idle.
- Reject: tile_occupied = 1 constantly -> 16 tile_rd_en strobes, then a 1-cycle fail pulse; no place_valid; the cycle repeats while enable = 1.
- Eat: with the table full, eat_valid at a stored point -> active_count 4->3 next cycle, then a new distinct point is placed. eat at (0,0) -> no change.
- Backpressure/abort: place_ready = 0 for 10 cycles -> place_valid held, place_x/y stable. Drop enable -> place_valid = 0 next cycle, active_count unchanged.
- Seed: seed_load with 0 behaves identically to seed 1. Two runs with the same seed produce identical placement sequences.

Source files
------------

// File: rtl/point_spawner.sv
// Food point spawner for the snake game.
// Keeps up to N_POINTS points live on the map. Candidates come from a
// Galois LFSR, are probed against the tile map and the point table, and
// the survivors are offered to the map-update logic.
//
// Handshake (place_*): place_valid is raised only in PLACE and stays high,
// with place_x/place_y stable, until the cycle where place_valid and
// place_ready are both high; that cycle is the transfer. place_valid never
// depends combinationally on place_ready.
module point_spawner #(
    parameter int MAP_W     = 32,
    parameter int MAP_H     = 24,
    parameter int N_POINTS  = 4,
    parameter int LFSR_W    = 16,
    parameter int MAX_TRIES = 16,
    localparam int XW = $clog2(MAP_W),
    localparam int YW = $clog2(MAP_H),
    localparam int CW = $clog2(N_POINTS + 1)
) (
    input  logic              clk_75,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              eat_valid,
    input  logic [XW-1:0]     eat_x,
    input  logic [YW-1:0]     eat_y,
    output logic              tile_rd_en,
    output logic [XW-1:0]     tile_rd_x,
    output logic [YW-1:0]     tile_rd_y,
    input  logic              tile_occupied,
    output logic              place_valid,
    output logic [XW-1:0]     place_x,
    output logic [YW-1:0]     place_y,
    input  logic              place_ready,
    output logic [CW-1:0]     active_count,
    output logic              busy,
    output logic              fail
);

    localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam int IW = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;

    localparam logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(16'hB400);
    localparam logic [LFSR_W-1:0] LFSR_ONE  = LFSR_W'(1);
    localparam logic [7:0]        X_SPAN    = 8'(MAP_W - 2);
    localparam logic [7:0]        Y_SPAN    = 8'(MAP_H - 2);
    localparam logic [TW-1:0]     LAST_TRY  = TW'(MAX_TRIES - 1);
    localparam logic [CW-1:0]     FULL_CNT  = CW'(N_POINTS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PICK  = 3'd1,
        S_PROBE = 3'd2,
        S_CHECK = 3'd3,
        S_PLACE = 3'd4
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [LFSR_W-1:0]   lfsr;
    logic [7:0]          cx_wide;
    logic [7:0]          cy_wide;
    logic [XW-1:0]       cand_x;
    logic [YW-1:0]       cand_y;
    logic [TW-1:0]       try_cnt;
    logic                fail_q;

    logic [N_POINTS-1:0] slot_valid;
    logic [XW-1:0]       slot_x [N_POINTS];
    logic [YW-1:0]       slot_y [N_POINTS];

    logic [IW-1:0]       free_idx;
    logic                cand_dup;
    logic [CW-1:0]       live_cnt;
    logic                deficit;
    logic                reject;
    logic                last_try;
    logic                check_go;
    logic                fail_set;
    logic                accept;

    // Candidate coordinates folded into the playable interior (walls excluded).
    assign cx_wide = (lfsr[7:0] % X_SPAN) + 8'd1;
    assign cy_wide = (lfsr[15:8] % Y_SPAN) + 8'd1;

    // Table lookups: lowest free slot, duplicate detection and live count.
    always_comb begin
        free_idx = '0;
        cand_dup = 1'b0;
        live_cnt = '0;
        for (int i = N_POINTS - 1; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                free_idx = IW'(i);
            end
            if (slot_valid[i] && slot_x[i] == cand_x && slot_y[i] == cand_y) begin
                cand_dup = 1'b1;
            end
            live_cnt = live_cnt + CW'(slot_valid[i]);
        end
    end

    // Decision terms shared by the FSM and the datapath.
    always_comb begin
        deficit  = live_cnt < FULL_CNT;
        reject   = tile_occupied || cand_dup;
        last_try = try_cnt == LAST_TRY;
        check_go = (state == S_CHECK) && enable && !clear;
        fail_set = check_go && reject && last_try;
        // An offer already on the bus completes even if enable drops; clear wins.
        accept   = (state == S_PLACE) && place_ready && !clear;
    end

    // LFSR: seed load beats the free-running advance; a zero seed becomes 1.
    always_ff @(posedge clk_75) begin
        if (rst) begin
            lfsr <= LFSR_ONE;
        end else if (seed_load) begin
            lfsr <= (seed == '0) ? LFSR_ONE : seed;
        end else begin
            lfsr <= {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
        end
    end

    // Candidate register, loaded from the LFSR while in PICK.
    always_ff @(posedge clk_75) begin
        if (rst) begin
            cand_x <= '0;
            cand_y <= '0;
        end else if (state == S_PICK) begin
            cand_x <= cx_wide[XW-1:0];
            cand_y <= cy_wide[YW-1:0];
        end
    end

    // Try counter: counts rejected candidates of the current placement.
    always_ff @(posedge clk_75) begin
        if (rst) begin
            try_cnt <= '0;
        end else if (clear || !enable || accept || fail_set) begin
            try_cnt <= '0;
        end else if (check_go && reject) begin
            try_cnt <= try_cnt + TW'(1);
        end
    end

    // Fail pulse, one cycle after the last rejected CHECK.
    always_ff @(posedge clk_75) begin
        if (rst) begin
            fail_q <= 1'b0;
        end else begin
            fail_q <= fail_set;
        end
    end

    // Point table: eaten points are invalidated, accepted points fill the lowest free slot.
    always_ff @(posedge clk_75) begin
        if (rst || clear) begin
            slot_valid <= '0;
        end else begin
            for (int i = 0; i < N_POINTS; i++) begin
                if (eat_valid && slot_valid[i] && slot_x[i] == eat_x && slot_y[i] == eat_y) begin
                    slot_valid[i] <= 1'b0;
                end
            end
            if (accept) begin
                slot_valid[free_idx] <= 1'b1;
                slot_x[free_idx]     <= cand_x;
                slot_y[free_idx]     <= cand_y;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_75) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; enable low or clear always returns to IDLE.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (enable && deficit && !clear) state_next = S_PICK;
            S_PICK:  state_next = S_PROBE;
            S_PROBE: state_next = S_CHECK;
            S_CHECK: begin
                if (reject) begin
                    state_next = last_try ? S_IDLE : S_PICK;
                end else begin
                    state_next = S_PLACE;
                end
            end
            S_PLACE: if (place_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (!enable || clear) begin
            state_next = S_IDLE;
        end
    end

    // FSM outputs, all decoded from registered state.
    always_comb begin
        tile_rd_en   = (state == S_PROBE);
        place_valid  = (state == S_PLACE);
        busy         = (state != S_IDLE);
        tile_rd_x    = cand_x;
        tile_rd_y    = cand_y;
        place_x      = cand_x;
        place_y      = cand_y;
        active_count = live_cnt;
        fail         = fail_q;
    end

endmodule

// File: tb/tb_point_spawner.sv
// Bench for point_spawner: a behavioural reference model (point list as a
// queue, LFSR as plain arithmetic) compared every cycle, plus directed
// phases with hand-computed expectations and a randomized soak.
module tb_point_spawner;

    localparam int MAP_W     = 32;
    localparam int MAP_H     = 24;
    localparam int N_POINTS  = 4;
    localparam int MAX_TRIES = 16;

    logic        clk_75 = 1'b0;
    logic        rst;
    logic        enable;
    logic        clear;
    logic        seed_load;
    logic [15:0] seed;
    logic        eat_valid;
    logic [4:0]  eat_x;
    logic [4:0]  eat_y;
    logic        tile_rd_en;
    logic [4:0]  tile_rd_x;
    logic [4:0]  tile_rd_y;
    logic        tile_occupied;
    logic        place_valid;
    logic [4:0]  place_x;
    logic [4:0]  place_y;
    logic        place_ready;
    logic [2:0]  active_count;
    logic        busy;
    logic        fail;

    int checks = 0;
    int errors = 0;

    point_spawner dut (
        .clk_75       (clk_75),
        .rst          (rst),
        .enable       (enable),
        .clear        (clear),
        .seed_load    (seed_load),
        .seed         (seed),
        .eat_valid    (eat_valid),
        .eat_x        (eat_x),
        .eat_y        (eat_y),
        .tile_rd_en   (tile_rd_en),
        .tile_rd_x    (tile_rd_x),
        .tile_rd_y    (tile_rd_y),
        .tile_occupied(tile_occupied),
        .place_valid  (place_valid),
        .place_x      (place_x),
        .place_y      (place_y),
        .place_ready  (place_ready),
        .active_count (active_count),
        .busy         (busy),
        .fail         (fail)
    );

    // Clock.
    always #5 clk_75 = ~clk_75;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_75);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_lfsr = 16'h1;
    logic [9:0]  m_pts[$];          // live points as {x, y}
    int          m_age = -1;        // cycles into the current attempt, -1 when idle
    int          m_tries = 0;
    logic [4:0]  m_cx = '0;
    logic [4:0]  m_cy = '0;
    logic        m_fail = 1'b0;
    logic        model_ready = 1'b0;

    function automatic logic [15:0] galois(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic has_point(input logic [9:0] p);
        foreach (m_pts[i]) if (m_pts[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk_75) begin : ref_model
        logic [15:0] old_l;
        logic        acc;
        logic        rejected;
        int          n0;
        model_ready = 1'b1;
        old_l  = m_lfsr;
        m_fail = 1'b0;
        if (rst) begin
            m_lfsr  = 16'h1;
            m_pts.delete();
            m_age   = -1;
            m_tries = 0;
            m_cx    = '0;
            m_cy    = '0;
        end else begin
            m_lfsr = seed_load ? ((seed == 16'h0) ? 16'h1 : seed) : galois(old_l);
            if (clear) begin
                m_pts.delete();
                m_age   = -1;
                m_tries = 0;
            end else begin
                n0       = m_pts.size();
                acc      = (m_age == 3) && place_ready;
                rejected = tile_occupied || has_point({m_cx, m_cy});
                if (eat_valid) begin
                    for (int i = 0; i < m_pts.size(); i++) begin
                        if (m_pts[i] == {eat_x, eat_y}) begin
                            m_pts.delete(i);
                            break;
                        end
                    end
                end
                if (acc) begin
                    m_pts.push_back({m_cx, m_cy});
                    m_age   = -1;
                    m_tries = 0;
                end else if (!enable) begin
                    m_age   = -1;
                    m_tries = 0;
                end else if (m_age == -1) begin
                    if (n0 < N_POINTS) m_age = 0;
                end else if (m_age == 0) begin
                    m_cx  = 5'((int'(old_l[7:0]) % (MAP_W - 2)) + 1);
                    m_cy  = 5'((int'(old_l[15:8]) % (MAP_H - 2)) + 1);
                    m_age = 1;
                end else if (m_age == 1) begin
                    m_age = 2;
                end else if (m_age == 2) begin
                    if (!rejected) begin
                        m_age = 3;
                    end else if (m_tries < MAX_TRIES - 1) begin
                        m_tries++;
                        m_age = 0;
                    end else begin
                        m_fail  = 1'b1;
                        m_tries = 0;
                        m_age   = -1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_75) begin
        if (model_ready) begin
            check("busy", busy, m_age >= 0);
            check("tile_rd_en", tile_rd_en, m_age == 1);
            check("place_valid", place_valid, m_age == 3);
            check("fail", fail, m_fail);
            check("active_count", active_count, m_pts.size());
            if (m_age == 1) check("tile_rd_xy", {tile_rd_x, tile_rd_y}, {m_cx, m_cy});
            if (m_age == 3) check("place_xy", {place_x, place_y}, {m_cx, m_cy});
        end
    end

    // Observed DUT activity for the directed phases.
    logic [9:0] acc_q[$];
    int         strobes   = 0;
    int         pv_cycles = 0;

    always @(negedge clk_75) begin
        if (place_valid && place_ready) acc_q.push_back({place_x, place_y});
        if (tile_rd_en) strobes++;
        if (place_valid) pv_cycles++;
    end

    // Clear the table, load a seed, then fill; returns the first four placements.
    task automatic run_seed(input logic [15:0] s, output logic [39:0] seq);
        int base;
        int n;
        logic [9:0] p;
        enable = 1'b0;
        clear  = 1'b1;
        tick();
        clear     = 1'b0;
        seed      = s;
        seed_load = 1'b1;
        tick();
        seed_load     = 1'b0;
        enable        = 1'b1;
        place_ready   = 1'b1;
        tile_occupied = 1'b0;
        base = acc_q.size();
        n    = 0;
        while (acc_q.size() < base + 4 && n < 100) begin
            tick();
            n++;
        end
        check("seed_run_accepts", acc_q.size() >= base + 4, 1);
        seq = '0;
        for (int k = 0; k < 4; k++) begin
            p = (base + k < acc_q.size()) ? acc_q[base + k] : 10'h0;
            seq[39 - 10 * k -: 10] = p;
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : stimulus
        int n;
        int bad;
        int pv0;
        logic [4:0]  hx, hy;
        logic [9:0]  p, q;
        logic [39:0] s0, s1, sa, sb;

        rst           = 1'b1;
        enable        = 1'b0;
        clear         = 1'b0;
        seed_load     = 1'b0;
        seed          = 16'h0;
        eat_valid     = 1'b0;
        eat_x         = '0;
        eat_y         = '0;
        tile_occupied = 1'b0;
        place_ready   = 1'b0;

        // Reset values.
        repeat (3) tick();
        check("rst_active_count", active_count, 0);
        check("rst_place_valid", place_valid, 0);
        check("rst_tile_rd_en", tile_rd_en, 0);
        check("rst_fail", fail, 0);
        check("rst_busy", busy, 0);
        check("rst_place_xy", {place_x, place_y}, 0);
        check("rst_tile_rd_xy", {tile_rd_x, tile_rd_y}, 0);
        rst = 1'b0;

        // Fill from seed ACE1: first candidate comes from galois(ACE1) = E270 -> (23,7).
        seed      = 16'hACE1;
        seed_load = 1'b1;
        tick();
        seed_load     = 1'b0;
        enable        = 1'b1;
        place_ready   = 1'b1;
        tile_occupied = 1'b0;
        n = 0;
        while (!place_valid && n < 20) begin
            tick();
            n++;
        end
        check("first_latency", n, 4);
        check("first_x", place_x, 23);
        check("first_y", place_y, 7);
        repeat (40) tick();
        check("fill_accepts", acc_q.size(), 4);
        check("fill_count", active_count, 4);
        check("fill_idle", busy, 0);
        bad = 0;
        for (int i = 0; i < acc_q.size(); i++) begin
            p = acc_q[i];
            if (p[9:5] < 1 || p[9:5] > 30 || p[4:0] < 1 || p[4:0] > 22) bad++;
            for (int j = 0; j < i; j++) if (acc_q[j] == p) bad++;
        end
        check("fill_range_distinct", bad, 0);

        // Eat a stored point, expect a refill with a distinct point.
        p         = acc_q[1];
        eat_x     = p[9:5];
        eat_y     = p[4:0];
        eat_valid = 1'b1;
        tick();
        eat_valid = 1'b0;
        check("eat_count", active_count, 3);
        repeat (20) tick();
        check("refill_count", active_count, 4);
        check("refill_accepts", acc_q.size(), 5);
        bad = 0;
        if (acc_q.size() >= 5) begin
            q = acc_q[4];
            if (q == acc_q[0] || q == acc_q[2] || q == acc_q[3]) bad++;
        end
        check("refill_distinct", bad, 0);
        eat_x     = 5'd0;
        eat_y     = 5'd0;
        eat_valid = 1'b1;
        tick();
        eat_valid = 1'b0;
        check("eat_nomatch_count", active_count, 4);
        tick();
        check("eat_nomatch_idle", busy, 0);

        // Every probe reports occupied: 16 strobes then a one-cycle fail, repeatedly.
        clear = 1'b1;
        tick();
        clear         = 1'b0;
        tile_occupied = 1'b1;
        pv0     = pv_cycles;
        strobes = 0;
        n = 0;
        while (!fail && n < 200) begin
            tick();
            n++;
        end
        check("reject_fail_seen", fail, 1);
        check("reject_strobes", strobes, MAX_TRIES);
        tick();
        check("fail_width", fail, 0);
        strobes = 0;
        n = 0;
        while (!fail && n < 200) begin
            tick();
            n++;
        end
        check("reject2_fail_seen", fail, 1);
        check("reject2_strobes", strobes, MAX_TRIES);
        check("reject_no_place", pv_cycles - pv0, 0);

        // Backpressure holds the offer; dropping enable aborts it.
        clear = 1'b1;
        tick();
        clear         = 1'b0;
        tile_occupied = 1'b0;
        place_ready   = 1'b0;
        n = 0;
        while (!place_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_offer", place_valid, 1);
        hx = place_x;
        hy = place_y;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_hold", {place_valid, place_x, place_y}, {1'b1, hx, hy});
        end
        enable = 1'b0;
        tick();
        check("abort_place_valid", place_valid, 0);
        check("abort_count", active_count, 0);
        check("abort_busy", busy, 0);

        // Seeds: 0 behaves as 1 (first point from B400 -> (1,5)); same seed repeats.
        run_seed(16'h0000, s0);
        run_seed(16'h0001, s1);
        check("seed0_eq_seed1", s0, s1);
        check("seed1_first", s1[39:30], {5'd1, 5'd5});
        run_seed(16'hACE1, sa);
        run_seed(16'hACE1, sb);
        check("seed_repeat", sa, sb);
        check("seed_ace1_first", sa[39:30], {5'd23, 5'd7});

        // Reset while an offer is pending.
        clear = 1'b1;
        tick();
        clear       = 1'b0;
        place_ready = 1'b0;
        n = 0;
        while (!place_valid && n < 20) begin
            tick();
            n++;
        end
        check("rstmid_offer", place_valid, 1);
        rst = 1'b1;
        tick();
        check("rstmid_place_valid", place_valid, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_count", active_count, 0);
        rst = 1'b0;

        // Randomized soak against the model.
        for (int c = 0; c < 3000; c++) begin
            rst           = ($urandom_range(0, 999) == 0);
            enable        = ($urandom_range(0, 19) != 0);
            clear         = ($urandom_range(0, 99) == 0);
            seed_load     = ($urandom_range(0, 99) == 0);
            seed          = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            tile_occupied = ($urandom_range(0, 3) == 0);
            place_ready   = ($urandom_range(0, 9) < 7);
            eat_valid     = ($urandom_range(0, 7) == 0);
            if (m_pts.size() > 0 && $urandom_range(0, 3) != 0) begin
                p = m_pts[$urandom_range(0, m_pts.size() - 1)];
            end else begin
                p = 10'($urandom);
            end
            eat_x = p[9:5];
            eat_y = p[4:0];
            tick();
        end
        rst       = 1'b0;
        clear     = 1'b0;
        seed_load = 1'b0;
        eat_valid = 1'b0;
        enable    = 1'b0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
